rps_referee: RTL and testbench
==============================

Name: rps_referee

Overview:
- Round controller upstream of the Markov predictor in the rock-paper-scissors game.
- Accepts a player move, converts the predictor's guess into the AI's counter-move, judges the round and keeps score.
- Publishes the {ai, player} pair as `combination`, which is the predictor's history input.
- Score and result outputs drive the HEX/LEDR display logic in the top level.

Parameters:
- SCORE_W, 4, width of each score counter.
- MAX_SCORE, 9, a player or the AI reaching this score ends the match.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- move_valid  in  1  one-cycle pulse: player_move is presented.
- player_move  in  2  0 rock, 1 paper, 2 scissors; 3 illegal.
- ai_guess  in  2  predictor's guess of the player's move, same encoding.
- new_game  in  1  pulse that clears scores and leaves GAME_OVER.
- busy  out  1  high whenever state is not IDLE.
- combination  out  4  [3:2] AI move played, [1:0] player move.
- combo_valid  out  1  one-cycle pulse when combination is updated.
- result  out  2  0 tie, 1 player win, 2 AI win, 3 none yet.
- player_score  out  SCORE_W  player round wins.
- ai_score  out  SCORE_W  AI round wins.
- round_count  out  8  rounds judged, wraps at 255 to 0.
- game_over  out  1  high in GAME_OVER.

Behaviour:
- Reset (synchronous, active-high) values:
  - State IDLE.
  - busy=0, combination=0, combo_valid=0, result=3.
  - Both scores 0, round_count 0, game_over 0.
- States: IDLE, JUDGE, REPORT, GAME_OVER.
- IDLE:
  - On move_valid with player_move != 3: latch player_move.
  - In the same cycle, latch ai_move = (ai_guess + 1) mod 3.
  - If ai_guess == 3, treat it as 0, so ai_move = 1.
  - Go to JUDGE.
  - move_valid with player_move == 3 is ignored; no state change.
- JUDGE (cycle +1):
  - Tie when player == ai.
  - Player wins when player == (ai + 1) mod 3.
  - Otherwise the AI wins.
  - Update result and increment the winner's score; no change on a tie.
  - Increment round_count.
  - Go to REPORT.
- REPORT (cycle +2):
  - combination <= {ai_move, player_move}; combo_valid=1 for exactly this cycle.
  - If either score == MAX_SCORE, go to GAME_OVER, else IDLE.
- GAME_OVER:
  - game_over=1, busy=1; all move_valid ignored.
  - new_game clears scores, round_count and result (to 3), then goes to IDLE next cycle.
  - combination holds its last value.
- Latency: combo_valid asserts exactly 2 cycles after the accepted move_valid. Minimum round spacing is 3 cycles.
- move_valid while busy is dropped, not queued.
- Scores never exceed MAX_SCORE: the match ends on reaching it, and no increment happens in GAME_OVER.
- new_game in IDLE clears the counters and result. new_game in JUDGE or REPORT is ignored.
- reset has priority over new_game and move_valid in any state, including mid-round: no combo_valid is emitted.
- combination and result hold their values between rounds.

Optional Feature:
- Macro RPS_STREAK_EN.
- Defined:
  - Adds output `best_streak` [SCORE_W-1:0], the longest run of consecutive player wins.
  - The current-run counter increments on a player win and clears on a tie or AI win.
  - best_streak takes the maximum of itself and the run, updated in REPORT.
  - Both clear on reset and new_game.
- Undefined: the port and both registers are absent; all other behaviour is identical.

Decomposition:
- Package rps_pkg:
  - Move encodings ROCK=0, PAPER=1, SCISSORS=2.
  - Result encodings TIE=0, P_WIN=1, AI_WIN=2, NONE=3.
  - State enum for this block.
  - Function beats(m) = (m+1) mod 3.
- One sub-module, rps_judge: combinational {player, ai} -> result. It is reused by the display logic.

Test Plan:
- Reset, then move_valid with player=0 and ai_guess=0:
  - ai_move=1, so the AI wins.
  - Cycle +2: combo_valid=1, combination=4'b0100, result=2, ai_score=1, round_count=1.
- player=2, ai_guess=2 (ai_move=0) -> result=2.
- player=1, ai_guess=2 (ai_move=0) -> result=1, player_score increments.
- player=3 pulse in IDLE -> busy stays 0, no combo_valid, counters unchanged.
- Two move_valid pulses 1 cycle apart -> only the first is judged; round_count increments by 1.
- Nine AI-winning rounds:
  - ai_score=9, game_over=1; a further move_valid is ignored.
  - new_game clears scores to 0 and result to 3; IDLE resumes.
- reset asserted in JUDGE -> all outputs return to reset values next cycle, and no combo_valid appears.
- With RPS_STREAK_EN, sequence P-win, P-win, tie, P-win -> best_streak=2.

Source files
------------

// File: rtl/rps_pkg.sv
// ============================================================================
// Module  : rps_pkg
// Brief   : Shared encodings, state type and helper for the RPS round logic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rps_pkg;

   localparam logic [1:0] ROCK         = 2'd0;
   localparam logic [1:0] PAPER        = 2'd1;
   localparam logic [1:0] SCISSORS     = 2'd2;
   localparam logic [1:0] ILLEGAL_MOVE = 2'd3;

   localparam logic [1:0] TIE    = 2'd0;
   localparam logic [1:0] P_WIN  = 2'd1;
   localparam logic [1:0] AI_WIN = 2'd2;
   localparam logic [1:0] NONE   = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      JUDGE     = 2'd1,
      REPORT    = 2'd2,
      GAME_OVER = 2'd3
   } state_t;

   // Move that defeats m; only defined for legal moves
   function automatic logic [1:0] beats(input logic [1:0] m);
      return (m == SCISSORS) ? ROCK : m + 2'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rps_judge.sv
// ============================================================================
// Module  : rps_judge
// Brief   : Combinational round judge, {player, ai} -> result.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rps_judge
   import rps_pkg::*;
(
   input  logic [1:0] player,
   input  logic [1:0] ai,
   output logic [1:0] result
);

   always_comb begin
      result = AI_WIN;
      if (player == ai)
         result = TIE;
      else if (player == beats(ai))
         result = P_WIN;
   end

endmodule

`default_nettype wire

// File: rtl/rps_referee.sv
// ============================================================================
// Module  : rps_referee
// Brief   : Round controller: AI counter-move, judging, scoring, match end.
//           Optional macro RPS_STREAK_EN adds the best_streak output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rps_referee
   import rps_pkg::*;
#(
   parameter int SCORE_W   = 4,
   parameter int MAX_SCORE = 9
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               move_valid,
   input  logic [1:0]         player_move,
   input  logic [1:0]         ai_guess,
   input  logic               new_game,
   output logic               busy,
   output logic [3:0]         combination,
   output logic               combo_valid,
   output logic [1:0]         result,
   output logic [SCORE_W-1:0] player_score,
   output logic [SCORE_W-1:0] ai_score,
   output logic [7:0]         round_count,
   output logic               game_over
`ifdef RPS_STREAK_EN
   ,output logic [SCORE_W-1:0] best_streak
`endif
);

   state_t             r_state;
   logic               r_busy;
   logic [3:0]         r_combination;
   logic               r_combo_valid;
   logic [1:0]         r_result;
   logic [SCORE_W-1:0] r_player_score;
   logic [SCORE_W-1:0] r_ai_score;
   logic [7:0]         r_round_count;
   logic               r_game_over;
   logic [1:0]         r_player_move;
   logic [1:0]         r_ai_move;
   logic [1:0]         w_round_result;
   logic               w_clear;
   logic               w_match_end;

   rps_judge u_judge (
      .player (r_player_move),
      .ai     (r_ai_move),
      .result (w_round_result)
   );

   assign w_clear     = new_game && ((r_state == IDLE) || (r_state == GAME_OVER));
   assign w_match_end = (r_player_score == SCORE_W'(MAX_SCORE)) ||
                        (r_ai_score == SCORE_W'(MAX_SCORE));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= IDLE;
         r_busy         <= 1'b0;
         r_combination  <= 4'd0;
         r_combo_valid  <= 1'b0;
         r_result       <= NONE;
         r_player_score <= '0;
         r_ai_score     <= '0;
         r_round_count  <= 8'd0;
         r_game_over    <= 1'b0;
         r_player_move  <= ROCK;
         r_ai_move      <= ROCK;
      end else begin
         r_combo_valid <= 1'b0;
         if (w_clear) begin
            r_player_score <= '0;
            r_ai_score     <= '0;
            r_round_count  <= 8'd0;
            r_result       <= NONE;
         end
         case (r_state)
            IDLE: begin
               if (!new_game && move_valid && (player_move != ILLEGAL_MOVE)) begin
                  r_player_move <= player_move;
                  r_ai_move     <= beats((ai_guess == ILLEGAL_MOVE) ? ROCK : ai_guess);
                  r_state       <= JUDGE;
                  r_busy        <= 1'b1;
               end
            end
            JUDGE: begin
               r_result      <= w_round_result;
               r_round_count <= r_round_count + 8'd1;
               if (w_round_result == P_WIN)
                  r_player_score <= r_player_score + SCORE_W'(1);
               else if (w_round_result == AI_WIN)
                  r_ai_score <= r_ai_score + SCORE_W'(1);
               // Registered here so the pair and its pulse are visible during REPORT
               r_combination <= {r_ai_move, r_player_move};
               r_combo_valid <= 1'b1;
               r_state       <= REPORT;
            end
            REPORT: begin
               if (w_match_end) begin
                  r_state     <= GAME_OVER;
                  r_game_over <= 1'b1;
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            GAME_OVER: begin
               if (new_game) begin
                  r_state     <= IDLE;
                  r_busy      <= 1'b0;
                  r_game_over <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef RPS_STREAK_EN
   logic [SCORE_W-1:0] r_run;
   logic [SCORE_W-1:0] r_best;

   always_ff @(posedge clock) begin
      if (reset || w_clear) begin
         r_run  <= '0;
         r_best <= '0;
      end else if (r_state == JUDGE) begin
         r_run <= (w_round_result == P_WIN) ? r_run + SCORE_W'(1) : '0;
      end else if ((r_state == REPORT) && (r_run > r_best)) begin
         r_best <= r_run;
      end
   end

   assign best_streak = r_best;
`endif

   assign busy         = r_busy;
   assign combination  = r_combination;
   assign combo_valid  = r_combo_valid;
   assign result       = r_result;
   assign player_score = r_player_score;
   assign ai_score     = r_ai_score;
   assign round_count  = r_round_count;
   assign game_over    = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_rps_referee.sv
// ============================================================================
// Module  : tb_rps_referee
// Brief   : Self-checking bench for rps_referee (vector table, random rounds).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rps_referee;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       move_valid = 1'b0;
   logic [1:0] player_move = 2'd0;
   logic [1:0] ai_guess = 2'd0;
   logic       new_game = 1'b0;
   logic       busy;
   logic [3:0] combination;
   logic       combo_valid;
   logic [1:0] result;
   logic [3:0] player_score;
   logic [3:0] ai_score;
   logic [7:0] round_count;
   logic       game_over;
`ifdef RPS_STREAK_EN
   logic [3:0] best_streak;
`endif

   int checks = 0;
   int failures = 0;

   // Reference model state
   int m_ps, m_as, m_rounds, m_result, m_comb, m_over, m_run, m_best;

   always #5 clock = ~clock;

   rps_referee #(.SCORE_W(4), .MAX_SCORE(9)) dut (
      .clock        (clock),
      .reset        (reset),
      .move_valid   (move_valid),
      .player_move  (player_move),
      .ai_guess     (ai_guess),
      .new_game     (new_game),
      .busy         (busy),
      .combination  (combination),
      .combo_valid  (combo_valid),
      .result       (result),
      .player_score (player_score),
      .ai_score     (ai_score),
      .round_count  (round_count),
      .game_over    (game_over)
`ifdef RPS_STREAK_EN
      ,.best_streak (best_streak)
`endif
   );

   typedef struct {
      int p;
      int g;
      int exp_result;
      int exp_comb;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_clear();
      m_ps = 0; m_as = 0; m_rounds = 0; m_result = 3;
      m_run = 0; m_best = 0; m_over = 0;
   endtask

   task automatic model_reset();
      model_clear();
      m_comb = 0;
   endtask

   // Outcome from modular difference: 0 tie, 1 player wins, 2 AI wins
   task automatic model_round(input int p, input int g);
      int ai, d;
      ai = (g == 3) ? 1 : (g + 1) % 3;
      d  = (p - ai + 3) % 3;
      m_result = d;
      if (d == 1) m_ps++;
      if (d == 2) m_as++;
      m_rounds = (m_rounds + 1) % 256;
      m_comb = ai * 4 + p;
      m_run = (d == 1) ? m_run + 1 : 0;
      if (m_run > m_best) m_best = m_run;
      m_over = (m_ps == 9 || m_as == 9) ? 1 : 0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_combination"}, int'(combination), m_comb);
      chk({tag, "_result"}, int'(result), m_result);
      chk({tag, "_player_score"}, int'(player_score), m_ps);
      chk({tag, "_ai_score"}, int'(ai_score), m_as);
      chk({tag, "_round_count"}, int'(round_count), m_rounds);
      chk({tag, "_game_over"}, int'(game_over), m_over);
   endtask

   task automatic play_round(input int p, input int g);
      move_valid = 1'b1;
      player_move = 2'(p);
      ai_guess = 2'(g);
      tick();
      move_valid = 1'b0;
      chk("judge_busy", int'(busy), 1);
      chk("judge_combo_valid", int'(combo_valid), 0);
      model_round(p, g);
      tick();
      chk("report_combo_valid", int'(combo_valid), 1);
      chk("report_combination", int'(combination), m_comb);
      chk("report_result", int'(result), m_result);
      chk("report_player_score", int'(player_score), m_ps);
      chk("report_ai_score", int'(ai_score), m_as);
      chk("report_round_count", int'(round_count), m_rounds);
      tick();
      chk("after_combo_valid", int'(combo_valid), 0);
      chk("after_game_over", int'(game_over), m_over);
      chk("after_busy", int'(busy), m_over);
`ifdef RPS_STREAK_EN
      chk("best_streak", int'(best_streak), m_best);
`endif
   endtask

   task automatic pulse_new_game();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      model_clear();
      chk("ng_busy", int'(busy), 0);
      check_state("ng");
`ifdef RPS_STREAK_EN
      chk("ng_best_streak", int'(best_streak), 0);
`endif
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_combo_valid"}, int'(combo_valid), 0);
      check_state(tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{p: 0, g: 0, exp_result: 2, exp_comb: 4'b0100};
      vecs[1] = '{p: 2, g: 2, exp_result: 2, exp_comb: 4'b0010};
      vecs[2] = '{p: 1, g: 2, exp_result: 1, exp_comb: 4'b0001};
      vecs[3] = '{p: 0, g: 1, exp_result: 1, exp_comb: 4'b1000};
      vecs[4] = '{p: 1, g: 1, exp_result: 2, exp_comb: 4'b1001};
      vecs[5] = '{p: 2, g: 1, exp_result: 0, exp_comb: 4'b1010};
      vecs[6] = '{p: 0, g: 3, exp_result: 2, exp_comb: 4'b0100};

      model_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      check_reset("reset");

      for (int i = 0; i < 7; i++) begin
         play_round(vecs[i].p, vecs[i].g);
         chk("vec_result", int'(result), vecs[i].exp_result);
         chk("vec_combination", int'(combination), vecs[i].exp_comb);
      end
      chk("vec_ai_score", int'(ai_score), 4);
      chk("vec_player_score", int'(player_score), 2);

      // Illegal move in IDLE is ignored
      move_valid = 1'b1; player_move = 2'd3; ai_guess = 2'd0;
      tick();
      move_valid = 1'b0;
      chk("illegal_busy", int'(busy), 0);
      tick();
      chk("illegal_combo_valid", int'(combo_valid), 0);
      tick();
      chk("illegal_combo_valid2", int'(combo_valid), 0);
      check_state("illegal");

      // Back-to-back pulses: second one arrives while busy and is dropped
      move_valid = 1'b1; player_move = 2'd0; ai_guess = 2'd0;
      tick();
      player_move = 2'd1; ai_guess = 2'd0;
      model_round(0, 0);
      tick();
      move_valid = 1'b0;
      chk("b2b_combo_valid", int'(combo_valid), 1);
      check_state("b2b");
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("b2b_no_second", int'(combo_valid), 0);
         tick();
      end
      check_state("b2b_end");

      // Random rounds against the model
      for (int i = 0; i < 40; i++) begin
         if (m_over != 0) break;
         repeat ($urandom_range(0, 2)) tick();
         play_round(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end
      pulse_new_game();

      // Nine AI wins end the match
      for (int i = 0; i < 9; i++) play_round(0, 0);
      chk("match_ai_score", int'(ai_score), 9);
      chk("match_game_over", int'(game_over), 1);
      move_valid = 1'b1; player_move = 2'd1; ai_guess = 2'd2;
      tick();
      move_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("over_no_combo", int'(combo_valid), 0);
         tick();
      end
      chk("over_busy", int'(busy), 1);
      check_state("over_hold");
      pulse_new_game();
      play_round(1, 2);

      // Reset mid-round, during JUDGE
      move_valid = 1'b1; player_move = 2'd2; ai_guess = 2'd0;
      tick();
      move_valid = 1'b0;
      chk("midrst_busy", int'(busy), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      check_reset("midrst");
      tick();
      chk("midrst_no_combo", int'(combo_valid), 0);
      tick();
      chk("midrst_no_combo2", int'(combo_valid), 0);

`ifdef RPS_STREAK_EN
      play_round(1, 2);
      play_round(1, 2);
      play_round(0, 2);
      play_round(1, 2);
      chk("streak_best", int'(best_streak), 2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
